// File: rtl/ps2_serial_keyboard_tx.sv
// PS/2 set-2 key events -> ASCII -> character FIFO -> 8N1 serial line for the machine's rx input.
// Optional build macro PS2TX_CRLF_EN: Enter queues CR then LF as an atomic pair.
module ps2_serial_keyboard_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [10:0]                   ps2_key,
  input  logic                          enable,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_START = 2'd1, ST_DATA = 2'd2, ST_STOP = 2'd3} tx_state_e;

  // Returns {valid, is_letter, ascii} for a non-extended set-2 make code.
  function automatic logic [9:0] xlate(input logic [7:0] code);
    case (code)
      8'h1C: xlate = {2'b11, 8'h41}; 8'h32: xlate = {2'b11, 8'h42}; 8'h21: xlate = {2'b11, 8'h43};
      8'h23: xlate = {2'b11, 8'h44}; 8'h24: xlate = {2'b11, 8'h45}; 8'h2B: xlate = {2'b11, 8'h46};
      8'h34: xlate = {2'b11, 8'h47}; 8'h33: xlate = {2'b11, 8'h48}; 8'h43: xlate = {2'b11, 8'h49};
      8'h3B: xlate = {2'b11, 8'h4A}; 8'h42: xlate = {2'b11, 8'h4B}; 8'h4B: xlate = {2'b11, 8'h4C};
      8'h3A: xlate = {2'b11, 8'h4D}; 8'h31: xlate = {2'b11, 8'h4E}; 8'h44: xlate = {2'b11, 8'h4F};
      8'h4D: xlate = {2'b11, 8'h50}; 8'h15: xlate = {2'b11, 8'h51}; 8'h2D: xlate = {2'b11, 8'h52};
      8'h1B: xlate = {2'b11, 8'h53}; 8'h2C: xlate = {2'b11, 8'h54}; 8'h3C: xlate = {2'b11, 8'h55};
      8'h2A: xlate = {2'b11, 8'h56}; 8'h1D: xlate = {2'b11, 8'h57}; 8'h22: xlate = {2'b11, 8'h58};
      8'h35: xlate = {2'b11, 8'h59}; 8'h1A: xlate = {2'b11, 8'h5A};
      8'h45: xlate = {2'b10, 8'h30}; 8'h16: xlate = {2'b10, 8'h31}; 8'h1E: xlate = {2'b10, 8'h32};
      8'h26: xlate = {2'b10, 8'h33}; 8'h25: xlate = {2'b10, 8'h34}; 8'h2E: xlate = {2'b10, 8'h35};
      8'h36: xlate = {2'b10, 8'h36}; 8'h3D: xlate = {2'b10, 8'h37}; 8'h3E: xlate = {2'b10, 8'h38};
      8'h46: xlate = {2'b10, 8'h39};
      8'h29: xlate = {2'b10, 8'h20}; 8'h5A: xlate = {2'b10, 8'h0D};
      8'h66: xlate = {2'b10, 8'h08}; 8'h76: xlate = {2'b10, 8'h1B};
      default: xlate = 10'd0;
    endcase
  endfunction

  logic            toggle_shadow_r, live_ev_s, src_ev_s, stall_s;
  logic [9:0]      src_key_s, xl_s;
  logic            ctrl_held_r, char_valid_r;
  logic [7:0]      char_r, push_data_s, head_s;
  logic            push_s, pop_s, drop_s, wr_en_s, full_s, nonempty_s;
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [7:0]      mem_r [FIFO_DEPTH];
  logic            overflow_r, tx_r, busy_r, tx_next_s, busy_next_s, bit_end_s;
  tx_state_e       state_r, state_next_s;
  logic [CNTW-1:0] clk_cnt_r;
  logic [2:0]      bit_cnt_r;
  logic [7:0]      shift_r, shift_next_s;

  assign live_ev_s = ps2_key[10] ^ toggle_shadow_r;

  // Toggle shadow tracks the strobe every cycle, including during reset.
  always_ff @(posedge clk) begin
    toggle_shadow_r <= ps2_key[10];
  end

`ifdef PS2TX_CRLF_EN
  logic       skid_valid_r, is_enter_r, lf_pending_r, cr_push_s;
  logic [9:0] skid_key_r;

  assign src_ev_s  = skid_valid_r | live_ev_s;
  assign src_key_s = skid_valid_r ? skid_key_r : ps2_key[9:0];
  assign stall_s   = cr_push_s;

  // Skid holds one event that arrives while the CR of a pair is being pushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_r <= 1'b0;
      skid_key_r   <= 10'd0;
    end else if (stall_s) begin
      if (!skid_valid_r && live_ev_s) begin
        skid_valid_r <= 1'b1;
        skid_key_r   <= ps2_key[9:0];
      end
    end else begin
      skid_valid_r <= skid_valid_r & live_ev_s;
      if (live_ev_s) skid_key_r <= ps2_key[9:0];
    end
  end

  // CR/LF pair sequencing: LF always follows an accepted CR on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      lf_pending_r <= 1'b0;
      is_enter_r   <= 1'b0;
    end else begin
      lf_pending_r <= cr_push_s;
      if (!stall_s) is_enter_r <= (src_key_s[7:0] == 8'h5A);
    end
  end

  // Push source selection with the two-free-entries check for Enter.
  always_comb begin
    push_s      = 1'b0;
    push_data_s = char_r;
    cr_push_s   = 1'b0;
    drop_s      = 1'b0;
    if (lf_pending_r) begin
      push_s      = 1'b1;
      push_data_s = 8'h0A;
    end else if (char_valid_r && enable) begin
      if (!is_enter_r) begin
        push_s = 1'b1;
      end else if (count_r <= CW'(FIFO_DEPTH - 2)) begin
        push_s    = 1'b1;
        cr_push_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
  end
`else
  assign src_ev_s    = live_ev_s;
  assign src_key_s   = ps2_key[9:0];
  assign stall_s     = 1'b0;
  assign push_s      = char_valid_r & enable;
  assign push_data_s = char_r;
  assign drop_s      = 1'b0;
`endif

  assign xl_s = xlate(src_key_s[7:0]);

  // Translation stage and ctrl tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      char_valid_r <= 1'b0;
      char_r       <= 8'd0;
      ctrl_held_r  <= 1'b0;
    end else if (stall_s) begin
      char_valid_r <= 1'b0;
    end else begin
      char_valid_r <= src_ev_s & src_key_s[9] & ~src_key_s[8] & xl_s[9];
      char_r       <= (xl_s[8] && ctrl_held_r) ? (xl_s[7:0] & 8'h1F) : xl_s[7:0];
      if (src_ev_s && !src_key_s[8] && (src_key_s[7:0] == 8'h14)) ctrl_held_r <= src_key_s[9];
    end
  end

  assign full_s     = (count_r == CW'(FIFO_DEPTH));
  assign nonempty_s = (count_r != CW'(0));
  assign wr_en_s    = push_s & (~full_s | pop_s);
  assign head_s     = mem_r[rd_ptr_r];

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= push_data_s;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= AW'(0);
      rd_ptr_r   <= AW'(0);
      count_r    <= CW'(0);
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)   rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if ((push_s && full_s && !pop_s) || drop_s) overflow_r <= 1'b1;
    end
  end

  assign bit_end_s = (clk_cnt_r == CNTW'(CLKS_PER_BIT - 1));

  // TX FSM state register with registered line and busy outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      tx_r    <= tx_next_s;
      busy_r  <= busy_next_s;
    end
  end

  // TX FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  state_next_s = nonempty_s ? ST_START : ST_IDLE;
      ST_START: state_next_s = bit_end_s ? ST_DATA : ST_START;
      ST_DATA:  state_next_s = (bit_end_s && (bit_cnt_r == 3'd7)) ? ST_STOP : ST_DATA;
      ST_STOP: begin
        if (bit_end_s) state_next_s = nonempty_s ? ST_START : ST_IDLE;
        else           state_next_s = ST_STOP;
      end
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // TX FSM outputs: pop strobe, next shift contents, next line level and busy.
  always_comb begin
    pop_s        = 1'b0;
    shift_next_s = shift_r;
    tx_next_s    = 1'b1;
    if ((state_r == ST_IDLE) || ((state_r == ST_STOP) && bit_end_s)) begin
      pop_s = nonempty_s;
    end else begin
      pop_s = 1'b0;
    end
    if (pop_s) begin
      shift_next_s = head_s;
    end else if ((state_r == ST_DATA) && bit_end_s) begin
      shift_next_s = {1'b0, shift_r[7:1]};
    end else begin
      shift_next_s = shift_r;
    end
    case (state_next_s)
      ST_IDLE:  tx_next_s = 1'b1;
      ST_START: tx_next_s = 1'b0;
      ST_DATA:  tx_next_s = shift_next_s[0];
      ST_STOP:  tx_next_s = 1'b1;
      default:  tx_next_s = 1'b1;
    endcase
    busy_next_s = (state_next_s != ST_IDLE) | nonempty_s;
  end

  // Bit timing counters and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt_r <= CNTW'(0);
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
    end else begin
      clk_cnt_r <= ((state_r == ST_IDLE) || bit_end_s) ? CNTW'(0) : clk_cnt_r + CNTW'(1);
      if (state_r != ST_DATA)  bit_cnt_r <= 3'd0;
      else if (bit_end_s)      bit_cnt_r <= bit_cnt_r + 3'd1;
      shift_r <= shift_next_s;
    end
  end

  assign tx         = tx_r;
  assign busy       = busy_r;
  assign fifo_count = count_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_ps2_serial_keyboard_tx.sv
// Directed bench for ps2_serial_keyboard_tx: a scoreboard of expected ASCII bytes is filled as
// keys are driven and drained by a serial-frame decoder watching tx.
module tb_ps2_serial_keyboard_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic        enable;
  logic        tx, busy, overflow;
  logic [4:0]  fifo_count;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_q[$];
  int          frames_rx = 0;
  bit          mon_active = 1'b0;
  int          cyc = 0;
  int          last_start = 0;
  int          gap_last = 0;

  ps2_serial_keyboard_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .enable(enable),
    .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input bit make, input bit ext, input logic [7:0] code);
    @(negedge clk);
    ps2_key = {~ps2_key[10], make, ext, code};
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy === 1'b1 || mon_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < budget) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
  endtask

  // Frame decoder: start bit on a falling edge, data sampled mid-bit, LSB first.
  initial begin
    logic       prev_tx;
    logic [7:0] mbyte;
    int         mcnt;
    prev_tx = 1'b1;
    mbyte   = 8'd0;
    mcnt    = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        mon_active = 1'b0;
        prev_tx    = 1'b1;
      end else begin
        if (!mon_active) begin
          if (tx === 1'b0 && prev_tx === 1'b1) begin
            mon_active = 1'b1;
            mcnt       = 0;
            gap_last   = cyc - last_start;
            last_start = cyc;
          end
        end else begin
          mcnt++;
          if (mcnt >= 5 && mcnt <= 33 && ((mcnt - 5) % 4) == 0) mbyte = {tx, mbyte[7:1]};
          if (mcnt == 37) begin
            check("stop_bit", int'(tx), 1);
            check("scoreboard_has_entry", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) check("frame_byte", int'(mbyte), int'(exp_q.pop_front()));
            frames_rx++;
          end
          if (mcnt == 39) mon_active = 1'b0;
        end
        prev_tx = tx;
      end
    end
  end

  initial begin
    int          busy_cnt, lows, peak, f0;
    logic [9:0]  pat;
    reset   = 1'b1;
    ps2_key = 11'd0;
    enable  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_count", int'(fifo_count), 0);
    check("reset_overflow", int'(overflow), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single 'A': latency, bit pattern and busy width.
    pat      = 10'h282;
    busy_cnt = 0;
    ps2_key  = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
    exp_q.push_back(8'h41);
    for (int e = 1; e <= 50; e++) begin
      @(negedge clk);
      if (e == 2) check("latency_pre", int'(tx), 1);
      if (e == 3) check("latency_fall", int'(tx), 0);
      if (e >= 4 && e <= 40 && ((e - 4) % 4) == 0) check("bit_pattern", int'(tx), int'(pat[(e - 4) / 4]));
      busy_cnt += int'(busy);
    end
    check("busy_cycles", busy_cnt, 40);
    wait_drain("drain_a", 200);

    // Ctrl-C followed by plain C, back to back.
    press(1'b1, 1'b0, 8'h14);
    press(1'b1, 1'b0, 8'h21); exp_q.push_back(8'h03);
    press(1'b0, 1'b0, 8'h14);
    press(1'b1, 1'b0, 8'h21); exp_q.push_back(8'h43);
    wait_drain("drain_ctrl", 400);
    check("back_to_back_gap", gap_last, 40);

    // Break, extended and unmapped codes produce nothing.
    f0 = frames_rx;
    press(1'b0, 1'b0, 8'h1C);
    press(1'b1, 1'b1, 8'h75);
    press(1'b1, 1'b0, 8'h0E);
    lows = 0;
    repeat (30) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    check("ignored_tx_low", lows, 0);
    check("ignored_count", int'(fifo_count), 0);
    check("ignored_busy", int'(busy), 0);
    check("ignored_frames", frames_rx - f0, 0);

    // Overflow: 20 spaces every 2 cycles.
    f0   = frames_rx;
    peak = 0;
    for (int i = 0; i < 20; i++) begin
      press(1'b1, 1'b0, 8'h29);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    for (int i = 0; i < DEPTH + 1; i++) exp_q.push_back(8'h20);
    repeat (10) begin @(negedge clk); if (int'(fifo_count) > peak) peak = int'(fifo_count); end
    check("overflow_peak", peak, DEPTH);
    check("overflow_flag", int'(overflow), 1);
    wait_drain("drain_overflow", 1200);
    check("overflow_frames", frames_rx - f0, DEPTH + 1);

    // Reset during data bit 3 with five characters queued.
    for (int i = 0; i < 6; i++) begin
      press(1'b1, 1'b0, 8'h1C);
      exp_q.push_back(8'h41);
    end
    repeat (9) @(negedge clk);
    check("pre_reset_count", int'(fifo_count), 5);
    check("pre_reset_tx", int'(tx), 0);
    check("pre_reset_overflow", int'(overflow), 1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midreset_tx", int'(tx), 1);
    check("midreset_count", int'(fifo_count), 0);
    check("midreset_overflow", int'(overflow), 0);
    check("midreset_busy", int'(busy), 0);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    f0    = frames_rx;
    lows  = 0;
    repeat (60) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    check("post_reset_quiet", lows, 0);
    check("post_reset_frames", frames_rx - f0, 0);
    press(1'b1, 1'b0, 8'h1C); exp_q.push_back(8'h41);
    wait_drain("drain_post_reset", 200);

    // Special keys, digits and ctrl on a non-letter.
    press(1'b1, 1'b0, 8'h5A); exp_q.push_back(8'h0D);
`ifdef PS2TX_CRLF_EN
    exp_q.push_back(8'h0A);
`endif
    press(1'b1, 1'b0, 8'h76); exp_q.push_back(8'h1B);
    press(1'b1, 1'b0, 8'h66); exp_q.push_back(8'h08);
    press(1'b1, 1'b0, 8'h45); exp_q.push_back(8'h30);
    press(1'b1, 1'b0, 8'h46); exp_q.push_back(8'h39);
    press(1'b1, 1'b0, 8'h1A); exp_q.push_back(8'h5A);
    press(1'b1, 1'b0, 8'h14);
    press(1'b1, 1'b0, 8'h16); exp_q.push_back(8'h31);
    press(1'b1, 1'b0, 8'h1A); exp_q.push_back(8'h1A);
    press(1'b0, 1'b0, 8'h14);
    wait_drain("drain_special", 800);

    // enable low discards; deasserting mid-frame keeps queued characters.
    enable = 1'b0;
    press(1'b1, 1'b0, 8'h1C);
    repeat (10) @(negedge clk);
    check("disabled_count", int'(fifo_count), 0);
    check("disabled_busy", int'(busy), 0);
    enable = 1'b1;
    press(1'b1, 1'b0, 8'h1C); exp_q.push_back(8'h41);
    press(1'b1, 1'b0, 8'h32); exp_q.push_back(8'h42);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    wait_drain("drain_enable", 300);
    enable = 1'b1;

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_serial_keyboard_tx.md
Name: ps2_serial_keyboard_tx

Overview:
Host-side terminal transmitter that feeds the machine's serial RX input. It takes MiSTer PS/2 key events from hps_io, translates set-2 make codes to ASCII, and buffers the characters in a FIFO. It then sends them as 8N1 async frames on a single line that drives the machine's rx, so the core can be used without an external serial terminal.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per serial bit (50 MHz / 9600 baud); legal values are 2 and above.
FIFO_DEPTH, 16, character FIFO entries; must be a power of 2, 2 to 256.

Ports:
clk  in  1  system clock; one clock domain only.
reset  in  1  synchronous, active-high reset.
ps2_key  in  11  [10] toggle strobe, [9] 1=make/0=break, [8] extended flag, [7:0] scancode.
enable  in  1  when 0, translated characters are discarded and nothing is queued.
tx  out  1  serial line output, idles high, 8N1, LSB first.
busy  out  1  high when a frame is in progress or the FIFO is non-empty.
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of queued characters.
overflow  out  1  sticky; set when a character is dropped because the FIFO is full.

Behaviour:
- Reset values: tx=1, busy=0, fifo_count=0, overflow=0. Reset also clears the FIFO, the TX FSM and the ctrl-held flag.
- While reset is high, the toggle shadow register loads ps2_key[10], so there is no spurious event after reset.
- Event detect: an event occurs when ps2_key[10] differs from the shadow register; the shadow register updates every cycle.
- Break events (ps2_key[9]=0):
  - Non-extended 0x14 clears ctrl_held.
  - All other break events are ignored.
- Make events (ps2_key[9]=1):
  - Non-extended 0x14 sets ctrl_held and emits no character.
  - Extended codes are ignored.
- Translation, non-extended codes only:
  - Letters map to uppercase ASCII (0x1C->0x41 'A', 0x21->0x43 'C', and so on for the full set-2 letter map).
  - Digits use the top row (0x45->0x30, 0x16->0x31 ... 0x46->0x39).
  - 0x29->0x20 space, 0x5A->0x0D Enter, 0x66->0x08 backspace, 0x76->0x1B Esc.
  - Codes not listed are dropped silently.
- Ctrl: if ctrl_held is set and the code is a letter, output = ASCII & 0x1F. Ctrl does not change any other key.
- Pipeline: event is sampled at cycle N, the translated character is registered at N+1, and the FIFO push happens at N+1. Push is qualified by enable and by a valid translation.
- FIFO: circular buffer with wrap-around read/write pointers.
  - A push and a pop in the same cycle are both honoured, even when the FIFO is full.
  - A push while full (with no pop in that cycle) drops the character and sets overflow.
  - A pop while empty is impossible; the FSM only pops when the FIFO is non-empty.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START. tx drops to 0 on the next edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each, counted by a 3-bit bit counter. Go to STOP after bit 7.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- End-to-end latency: tx falls 3 clk edges after the cycle in which the toggled ps2_key is sampled, when the FIFO starts empty and the FSM is in IDLE.
- enable deasserted mid-frame: the current frame and any already-queued characters still transmit.
- Reset mid-frame: tx=1 on the next edge and the FIFO is emptied. No partial frame resumes after reset.

Optional Feature:
Macro PS2TX_CRLF_EN.
- Defined: Enter queues 0x0D then 0x0A as an atomic pair.
  - The pair is pushed on consecutive cycles N+1 and N+2.
  - It is queued only if at least 2 entries are free at N+1; otherwise both characters are dropped and overflow is set.
  - Any event arriving at N+1 waits one cycle in a 1-entry skid register and is not lost.
- Undefined: Enter queues 0x0D only, and no skid register is built.

Test Plan:
- CLKS_PER_BIT=4, make 0x1C: tx low 3 edges later, then 4-cycle bits 0,1,0,0,0,0,0,1,0,1 (start, 0x41 LSB first, stop); busy high for 40 cycles.
- Make 0x14, make 0x21, break 0x14, make 0x21: frames 0x03 then 0x43; the second frame starts immediately after the first stop bit.
- Break 0x1C, extended make 0x75, make 0x0E (unmapped): tx stays 1, fifo_count=0, busy=0.
- FIFO_DEPTH=16, 20 make 0x29 events back-to-back every 2 cycles: fifo_count peaks at 16, overflow=1, exactly 17 frames of 0x20 are sent.
- Reset asserted during DATA bit 3 with 5 chars queued: next edge tx=1, fifo_count=0, overflow=0, no further frames; the first event after reset transmits normally.
- PS2TX_CRLF_EN: make 0x5A sends 0x0D,0x0A. With FIFO_DEPTH=2 and one entry occupied, make 0x5A drops both characters and sets overflow.
